criq_arb_ctrl: RTL and testbench
================================

// Module: criq_arb_ctrl
// PURPOSE
//  Controller that shares one circular issue queue between NREQ producers and one consumer.
//  Round-robin arbitration picks one push per cycle. Pops are gated by a valid/ready consumer handshake.
//  Flushes are sequenced through a small FSM. An occupancy count and an almost-full flag provide back-pressure.
//  Sits between decode-side producers and the queue instance; the queue itself is external.
// PARAMETERS
//  NREQ      2   number of push requesters (>=2)
//  CRIQWIDE  32  queue entry width
//  CRIQDEEP  7   queue max index; usable capacity = CRIQDEEP entries (one slot always empty)
//  PTRWIDE   3   queue pointer width; Count is PTRWIDE+1 bits
//  HOLDCYC   2   settle cycles after a flush before pushes/pops resume (>=1)
//  AFTHR     2   AlmostFull asserts when Count >= CRIQDEEP-AFTHR
// PORTS
//  Clk        in   1              clock
//  Rest       in   1              synchronous reset, active-high
//  ReqValid   in   NREQ           push request per requester
//  ReqData    in   NREQ*CRIQWIDE  packed data, requester i at [i*CRIQWIDE +: CRIQWIDE]
//  ReqGnt     out  NREQ           one-hot, same-cycle grant; data consumed when high
//  OutValid   out  1              head entry available to consumer
//  OutData    out  CRIQWIDE       head entry (QPreOut passthrough)
//  OutReady   in   1              consumer accepts head
//  FlushReq   in   1              flush request pulse
//  FlushDone  out  1              1-cycle pulse on re-entry to RUN after a flush
//  Count      out  PTRWIDE+1      current occupancy
//  AlmostFull out  1              Count >= CRIQDEEP-AFTHR
//  QWable     out  1              queue write strobe
//  QDin       out  CRIQWIDE       queue write data
//  QRable     out  1              queue read/advance strobe
//  QClean     out  1              queue pointer clear
//  QFull      in   1              queue full
//  QEmpty     in   1              queue empty
//  QPreOut    in   CRIQWIDE       queue head data
// BEHAVIOUR
//  FSM states: INIT, RUN, FLUSH, HOLD. Rest=1 -> state INIT, RrPtr=0, Count=0, HoldCnt=0.
//  While Rest=1, all strobes are 0: ReqGnt, QWable, QRable, OutValid, FlushDone.
//  INIT: QClean=1 for exactly one cycle, then RUN. No grants or pops in INIT.
//  RUN: a push is legal when !QFull; that cycle grants the first ReqValid at or after RrPtr, scanning
//   upward with wrap. ReqGnt[g]=1, QWable=1, QDin=ReqData[g]. Next cycle RrPtr=(g+1)%NREQ.
//   With no push, RrPtr holds.
//  RUN: OutValid=!QEmpty; OutData=QPreOut always; QRable=OutValid&OutReady.
//  Push and pop in the same cycle are allowed, including when full. QFull still blocks the push (no look-ahead).
//  Count: +1 on push only, -1 on pop only, unchanged on both or neither. Count saturates: never wraps
//   below 0 or above CRIQDEEP.
//  FlushReq in RUN (highest priority): the same cycle produces no grant and no pop. Next state is FLUSH.
//  FLUSH: QClean=1 for one cycle, Count<=0, HoldCnt<=HOLDCYC-1, then HOLD.
//  HOLD: decrement HoldCnt; at 0 go to RUN with FlushDone=1 on that transition cycle.
//  No grants or pops in FLUSH or HOLD.
//  FlushReq outside RUN is ignored and not queued.
//  Rest=1 mid-operation (any state) overrides everything and restarts at INIT, which re-cleans the queue.
//  AlmostFull is combinational from registered Count. Latency: grant and pop are same-cycle combinational.
//  All state updates are on the Clk rising edge.
// STRUCTURE
//  Shared package/header: FSM state encodings (S_INIT, S_RUN, S_FLUSH, S_HOLD, 2 bits).
//  Sub-module criq_rr_arb (NREQ): inputs ReqValid, RrPtr, Enable; outputs one-hot Gnt and binary GntIdx.
//  Top holds the FSM, the Count/HoldCnt registers, the RrPtr register, and the data mux.
// TESTING
//  Reset: hold Rest=1 3 cycles, release -> QClean=1 for 1 cycle, then RUN.
//   Count=0, ReqGnt=0, OutValid=0.
//  Round-robin: NREQ=2, both ReqValid=1 for 4 cycles, queue not full -> ReqGnt=01,10,01,10; Count=4.
//  Full back-pressure: fill to Count=7 (QFull=1), ReqValid=01 -> ReqGnt=00.
//   The same cycle with OutReady=1 -> QRable=1, Count=6. Next cycle the push is granted and Count=7.
//  Simultaneous: Count=3, ReqValid=10 and OutReady=1 -> ReqGnt=10, QWable=1, QRable=1, Count stays 3.
//  Flush: Count=5, FlushReq=1 -> no grant/pop that cycle; next cycle QClean=1, Count=0.
//   HOLDCYC=2 -> FlushDone=1 two cycles later, then RUN accepts pushes.
//  Reset mid-HOLD: Rest=1 during HOLD -> INIT, QClean pulses again, no FlushDone emitted.

Source files
------------

// File: rtl/criq_arb_ctrl_pkg.sv
// Shared types and helpers for the circular issue queue arbitration controller.
package criq_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HOLD  = 2'd3
  } criq_state_e;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/criq_arb_ctrl_if.sv
// Producer push and consumer pop handshake bundle of the issue queue controller.
interface criq_arb_ctrl_if #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned CRIQWIDE = 32
);
  logic [NREQ-1:0]          ReqValid;
  logic [NREQ*CRIQWIDE-1:0] ReqData;
  logic [NREQ-1:0]          ReqGnt;
  logic                     OutValid;
  logic [CRIQWIDE-1:0]      OutData;
  logic                     OutReady;

  modport master (
    output ReqValid, ReqData, OutReady,
    input  ReqGnt, OutValid, OutData
  );

  modport slave (
    input  ReqValid, ReqData, OutReady,
    output ReqGnt, OutValid, OutData
  );
endinterface

// File: rtl/criq_rr_arb.sv
// Combinational round-robin arbiter: first valid request at or after RrPtr, scanning upward with wrap.
module criq_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] ReqValid,
  input  logic [IDXW-1:0] RrPtr,
  input  logic            Enable,
  output logic [NREQ-1:0] Gnt,
  output logic [IDXW-1:0] GntIdx
);
  logic [IDXW-1:0] cand;
  logic            found;

  always_comb begin
    Gnt    = '0;
    GntIdx = '0;
    cand   = '0;
    found  = 1'b0;
    if (Enable) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        cand = IDXW'((32'(RrPtr) + i) % NREQ);
        if (!found && ReqValid[cand]) begin
          found     = 1'b1;
          GntIdx    = cand;
          Gnt[cand] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/criq_arb_ctrl.sv
// Shares one external circular issue queue between NREQ producers and a single consumer,
// with round-robin pushes, handshaked pops, sequenced flush and occupancy tracking.
module criq_arb_ctrl
  import criq_arb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned CRIQWIDE = 32,
  parameter int unsigned CRIQDEEP = 7,
  parameter int unsigned PTRWIDE  = 3,
  parameter int unsigned HOLDCYC  = 2,
  parameter int unsigned AFTHR    = 2
) (
  input  logic                Clk,
  input  logic                Rest,
  criq_arb_ctrl_if.slave      Bus,
  input  logic                FlushReq,
  output logic                FlushDone,
  output logic [PTRWIDE:0]    Count,
  output logic                AlmostFull,
  output logic                QWable,
  output logic [CRIQWIDE-1:0] QDin,
  output logic                QRable,
  output logic                QClean,
  input  logic                QFull,
  input  logic                QEmpty,
  input  logic [CRIQWIDE-1:0] QPreOut
);
  localparam int unsigned    IDXW    = $clog2(NREQ);
  localparam int unsigned    HCW     = (HOLDCYC > 1) ? $clog2(HOLDCYC) : 1;
  localparam logic [PTRWIDE:0] CNT_MAX = (PTRWIDE+1)'(CRIQDEEP);

  criq_state_e     state_q, state_d;
  logic [IDXW-1:0] rrptr_q, rrptr_d;
  logic [HCW-1:0]  holdcnt_q, holdcnt_d;
  logic [PTRWIDE:0] count_d;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            arb_en;
  logic            push;

  // A pending flush wins over any push in the same cycle.
  assign arb_en = (state_q == S_RUN) && !Rest && !FlushReq && !QFull;

  criq_rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .ReqValid (Bus.ReqValid),
    .RrPtr    (rrptr_q),
    .Enable   (arb_en),
    .Gnt      (gnt),
    .GntIdx   (gnt_idx)
  );

  assign push        = |gnt;
  assign Bus.ReqGnt  = gnt;
  assign QWable      = push;
  assign QDin        = Bus.ReqData[gnt_idx*CRIQWIDE +: CRIQWIDE];
  assign Bus.OutData = QPreOut;
  assign AlmostFull  = (int'(Count) >= int'(CRIQDEEP) - int'(AFTHR));

  always_comb begin
    state_d      = state_q;
    rrptr_d      = rrptr_q;
    holdcnt_d    = holdcnt_q;
    count_d      = Count;
    Bus.OutValid = 1'b0;
    QRable       = 1'b0;
    QClean       = 1'b0;
    FlushDone    = 1'b0;
    if (!Rest) begin
      unique case (state_q)
        S_INIT: begin
          QClean  = 1'b1;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (FlushReq) begin
            state_d = S_FLUSH;
          end else begin
            Bus.OutValid = !QEmpty;
            QRable       = !QEmpty && Bus.OutReady;
            if (push)
              rrptr_d = IDXW'(rr_next(32'(gnt_idx), NREQ));
            if (push && !QRable && Count != CNT_MAX)
              count_d = Count + 1'b1;
            else if (QRable && !push && Count != '0)
              count_d = Count - 1'b1;
          end
        end
        S_FLUSH: begin
          QClean    = 1'b1;
          count_d   = '0;
          holdcnt_d = HCW'(HOLDCYC - 1);
          state_d   = S_HOLD;
        end
        S_HOLD: begin
          if (holdcnt_q == '0) begin
            FlushDone = 1'b1;
            state_d   = S_RUN;
          end else begin
            holdcnt_d = holdcnt_q - HCW'(1);
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q   <= S_INIT;
      rrptr_q   <= '0;
      holdcnt_q <= '0;
      Count     <= '0;
    end else begin
      state_q   <= state_d;
      rrptr_q   <= rrptr_d;
      holdcnt_q <= holdcnt_d;
      Count     <= count_d;
    end
  end
endmodule

// File: tb/tb_criq_arb_ctrl.sv
// Randomized self-checking bench for criq_arb_ctrl; the bench also plays the external queue.
module tb_criq_arb_ctrl;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned W       = 32;
  localparam int unsigned DEEP    = 7;
  localparam int unsigned PW      = 3;
  localparam int unsigned HOLDCYC = 2;
  localparam int unsigned AFTHR   = 2;
  localparam int          NCYC    = 3000;

  logic          Clk = 1'b0;
  logic          Rest, FlushReq, FlushDone, AlmostFull;
  logic          QWable, QRable, QClean, QFull, QEmpty;
  logic [PW:0]   Count;
  logic [W-1:0]  QDin, QPreOut;

  criq_arb_ctrl_if #(.NREQ(NREQ), .CRIQWIDE(W)) bus ();

  criq_arb_ctrl #(
    .NREQ(NREQ), .CRIQWIDE(W), .CRIQDEEP(DEEP),
    .PTRWIDE(PW), .HOLDCYC(HOLDCYC), .AFTHR(AFTHR)
  ) dut (
    .Clk        (Clk),
    .Rest       (Rest),
    .Bus        (bus),
    .FlushReq   (FlushReq),
    .FlushDone  (FlushDone),
    .Count      (Count),
    .AlmostFull (AlmostFull),
    .QWable     (QWable),
    .QDin       (QDin),
    .QRable     (QRable),
    .QClean     (QClean),
    .QFull      (QFull),
    .QEmpty     (QEmpty),
    .QPreOut    (QPreOut)
  );

  always #5 Clk = ~Clk;

  // Reference model: queue contents, last granted requester, and a quiet window
  // (cycles with no traffic) that opens with a clean and, after a flush, closes with FlushDone.
  logic [W-1:0] q[$];
  int           last;
  int           quiet_len, quiet_left;
  bit           from_flush;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  int              g, idx, pv, pr, phase;
  logic [NREQ-1:0] exp_gnt;
  bit              exp_rd, exp_ov, exp_clean, exp_done, in_run;

  initial begin
    Rest         = 1'b1;
    FlushReq     = 1'b0;
    bus.ReqValid = '0;
    bus.ReqData  = '0;
    bus.OutReady = 1'b0;
    QFull        = 1'b0;
    QEmpty       = 1'b1;
    QPreOut      = '0;
    q.delete();
    last       = NREQ - 1;
    quiet_len  = 1;
    quiet_left = 1;
    from_flush = 1'b0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge Clk);
      phase = (cyc / 250) % 3;
      pv = (phase == 0) ? 80 : (phase == 1) ? 50 : 20;
      pr = (phase == 0) ? 20 : (phase == 1) ? 50 : 80;
      Rest = (cyc < 3) || ($urandom_range(0, 299) == 0) ||
             (from_flush && quiet_left == int'(HOLDCYC) && $urandom_range(0, 2) == 0);
      for (int i = 0; i < NREQ; i++) begin
        bus.ReqValid[i]        = ($urandom_range(0, 99) < pv);
        bus.ReqData[i*W +: W]  = $urandom;
      end
      bus.OutReady = ($urandom_range(0, 99) < pr);
      FlushReq     = ($urandom_range(0, 29) == 0);
      QFull        = (q.size() == DEEP);
      QEmpty       = (q.size() == 0);
      QPreOut      = (q.size() > 0) ? q[0] : W'($urandom);
      #1;

      exp_gnt   = '0;
      exp_rd    = 1'b0;
      exp_ov    = 1'b0;
      exp_clean = 1'b0;
      exp_done  = 1'b0;
      g         = -1;
      in_run    = !Rest && quiet_left == 0;
      if (!Rest && quiet_left > 0) begin
        exp_clean = (quiet_left == quiet_len);
        exp_done  = from_flush && quiet_left == 1;
      end
      if (in_run && !FlushReq) begin
        if (q.size() < DEEP)
          for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (g < 0 && bus.ReqValid[idx]) g = idx;
          end
        if (g >= 0) exp_gnt[g] = 1'b1;
        exp_ov = (q.size() > 0);
        exp_rd = exp_ov && bus.OutReady;
      end

      check_eq("ReqGnt", bus.ReqGnt, exp_gnt);
      check_eq("QWable", QWable, g >= 0);
      if (g >= 0) check_eq("QDin", QDin, bus.ReqData[g*W +: W]);
      check_eq("QRable", QRable, exp_rd);
      if (!(in_run && FlushReq)) check_eq("OutValid", bus.OutValid, exp_ov);
      check_eq("OutData", bus.OutData, QPreOut);
      check_eq("FlushDone", FlushDone, exp_done);
      if (!Rest) begin
        check_eq("QClean", QClean, exp_clean);
        check_eq("Count", Count, q.size());
        check_eq("AlmostFull", AlmostFull, q.size() >= int'(DEEP - AFTHR));
      end

      if (Rest) begin
        q.delete();
        last       = NREQ - 1;
        quiet_len  = 1;
        quiet_left = 1;
        from_flush = 1'b0;
      end else if (quiet_left > 0) begin
        if (quiet_left == quiet_len) q.delete();
        quiet_left--;
      end else if (FlushReq) begin
        quiet_len  = 1 + HOLDCYC;
        quiet_left = quiet_len;
        from_flush = 1'b1;
      end else begin
        if (exp_rd) void'(q.pop_front());
        if (g >= 0) begin
          q.push_back(bus.ReqData[g*W +: W]);
          last = g;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
